issue_scoreboard: RTL and testbench

- Issue controller between the decode stage and the execution units.
- Tracks pending register writes in a 64-entry scoreboard: 6-bit register address, bit 5 = float file, address 0 = int x0.
- Stalls decode on RAW/WAW hazards, serialises branches/jumps until resolved, and drains all outstanding writes before any I/O instruction issues.
- Register-address operands arrive as the decoder produces them; unused operands are presented as address 0.

---
 rtl/issue_scoreboard.sv | 122 ++++++++++++
 tb/tb_issue_scoreboard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Purpose : decode->execute issue control; 64-entry register-busy scoreboard, branch serialisation, I/O drain.
// Latency : zero added; issue is decided combinationally in the cycle dec_valid is presented.
// Backpr. : dec_ready (== issue) low on hazard, full window, unresolved branch, pending writes before I/O, or ex_ready low.
// Ports   : clk/rst (sync, active-high); dec_* decoded instruction in, dec_ready out; ex_ready in, issue out;
//           wb_valid/wb_a_rd writeback completion; br_done branch-resolved pulse;
//           outst, busy_vec, waiting_br, sb_err status outputs.
module issue_scoreboard #(
  parameter int MAX_OUTST    = 8,
  parameter int LEN_REG_ADDR = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dec_valid,
  output logic                          dec_ready,
  input  logic [LEN_REG_ADDR-1:0]       dec_a_rd,
  input  logic [LEN_REG_ADDR-1:0]       dec_a_rs1,
  input  logic [LEN_REG_ADDR-1:0]       dec_a_rs2,
  input  logic                          dec_jump,
  input  logic                          dec_branch,
  input  logic                          dec_io,
  input  logic                          ex_ready,
  output logic                          issue,
  input  logic                          wb_valid,
  input  logic [LEN_REG_ADDR-1:0]       wb_a_rd,
  input  logic                          br_done,
  output logic [3:0]                    outst,
  output logic [(1<<LEN_REG_ADDR)-1:0]  busy_vec,
  output logic                          waiting_br,
  output logic                          sb_err
);

  localparam int         NREG    = 1 << LEN_REG_ADDR;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_WAIT_BR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [3:0]        outst_q, outst_d;
  logic              err_q, err_d;

  logic rd_used, rs1_used, rs2_used;
  logic hz, cap_ok, io_ok, issue_w;
  logic set_en, wb_busy, wb_clr, wb_bad, br_bad;

  assign rd_used  = (dec_a_rd  != '0);
  assign rs1_used = (dec_a_rs1 != '0);
  assign rs2_used = (dec_a_rs2 != '0);

  // Hazards look only at the registered scoreboard: a writeback in the
  // current cycle releases its register for the next cycle, never this one.
  assign hz = (rs1_used & busy_q[dec_a_rs1]) |
              (rs2_used & busy_q[dec_a_rs2]) |
              (rd_used  & busy_q[dec_a_rd]);

  // Only register-writing instructions consume an outstanding slot.
  assign cap_ok = ~rd_used | (outst_q < MAX_CNT);
  // I/O must observe every earlier write completed.
  assign io_ok  = ~dec_io | (outst_q == 4'd0);

  assign issue_w = ~rst & (state_q == ST_RUN) & dec_valid & ex_ready &
                   ~hz & cap_ok & io_ok;

  assign issue     = issue_w;
  assign dec_ready = issue_w;

  assign set_en  = issue_w & rd_used;
  assign wb_busy = busy_q[wb_a_rd];
  assign wb_clr  = wb_valid & (wb_a_rd != '0) &  wb_busy;
  assign wb_bad  = wb_valid & (wb_a_rd != '0) & ~wb_busy;
  assign br_bad  = br_done & (state_q == ST_RUN);

  // Set and clear can never hit the same bit in one cycle: a busy rd blocks issue.
  always_comb begin
    busy_d = busy_q;
    if (set_en) busy_d[dec_a_rd] = 1'b1;
    if (wb_clr) busy_d[wb_a_rd]  = 1'b0;
  end

  always_comb begin
    outst_d = outst_q;
    case ({set_en, wb_clr})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
  end

  assign err_d = err_q | wb_bad | br_bad;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (issue_w & (dec_jump | dec_branch)) state_d = ST_WAIT_BR;
      ST_WAIT_BR: if (br_done)                           state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      busy_q  <= '0;
      outst_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign outst      = outst_q;
  assign busy_vec   = busy_q;
  assign waiting_br = (state_q == ST_WAIT_BR);
  assign sb_err     = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Purpose : directed bench for issue_scoreboard; expected issues queued by stimulus, popped by a monitor.
// Latency : expected issue cycle is stored with each queued entry and compared on issue.
// Backpr. : stimulus holds a stalled instruction until its expected issue cycle has passed.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dec_valid, dec_ready, dec_jump, dec_branch, dec_io;
  logic        ex_ready, issue, wb_valid, br_done, waiting_br, sb_err;
  logic [5:0]  dec_a_rd, dec_a_rs1, dec_a_rs2, wb_a_rd;
  logic [3:0]  outst;
  logic [63:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [5:0] rd;
  } exp_t;
  exp_t exp_q[$];

  issue_scoreboard #(.MAX_OUTST(8), .LEN_REG_ADDR(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_a_rd   (dec_a_rd),
    .dec_a_rs1  (dec_a_rs1),
    .dec_a_rs2  (dec_a_rs2),
    .dec_jump   (dec_jump),
    .dec_branch (dec_branch),
    .dec_io     (dec_io),
    .ex_ready   (ex_ready),
    .issue      (issue),
    .wb_valid   (wb_valid),
    .wb_a_rd    (wb_a_rd),
    .br_done    (br_done),
    .outst      (outst),
    .busy_vec   (busy_vec),
    .waiting_br (waiting_br),
    .sb_err     (sb_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every issue must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (dec_valid) check("dec_ready_eq_issue", dec_ready, issue);
    if (issue === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: issue=1 rd=%0d at cycle %0d, required no issue", dec_a_rd, cyc);
      end else begin
        e = exp_q.pop_front();
        check("issue_cycle", 64'(cyc), 64'(e.cyc));
        check("issue_rd", dec_a_rd, e.rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2,
                       input logic j, input logic b, input logic io);
    dec_valid  = 1'b1;
    dec_a_rd   = rd;
    dec_a_rs1  = rs1;
    dec_a_rs2  = rs2;
    dec_jump   = j;
    dec_branch = b;
    dec_io     = io;
  endtask

  task automatic idle();
    dec_valid  = 1'b0;
    dec_a_rd   = '0;
    dec_a_rs1  = '0;
    dec_a_rs2  = '0;
    dec_jump   = 1'b0;
    dec_branch = 1'b0;
    dec_io     = 1'b0;
  endtask

  task automatic expect_issue(input logic [5:0] rd, input int delay);
    exp_q.push_back('{cyc: cyc + delay, rd: rd});
  endtask

  task automatic wb_pulse(input logic [5:0] a);
    wb_valid = 1'b1;
    wb_a_rd  = a;
    tick();
    wb_valid = 1'b0;
    wb_a_rd  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a valid instruction present: nothing may issue.
    rst = 1'b1; ex_ready = 1'b1; wb_valid = 1'b0; wb_a_rd = '0; br_done = 1'b0;
    idle();
    drive(6'd3, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("reset_issue", issue, 1'b0);
    check("reset_dec_ready", dec_ready, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    check("reset_outst", outst, 4'd0);
    check("reset_busy", busy_vec, 64'd0);
    check("reset_waiting_br", waiting_br, 1'b0);
    check("reset_sb_err", sb_err, 1'b0);

    // RAW stall released by writeback, one cycle later.
    drive(6'd5, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'd5, 0);
    tick();
    check("raw_outst1", outst, 4'd1);
    check("raw_busy5", busy_vec[5], 1'b1);
    drive(6'd6, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'd6, 2);
    check("raw_stall", issue, 1'b0);
    tick();
    wb_valid = 1'b1; wb_a_rd = 6'd5;
    check("raw_no_bypass", issue, 1'b0);
    tick();
    wb_valid = 1'b0; wb_a_rd = '0;
    tick();
    idle();
    check("raw_outst_back1", outst, 4'd1);
    check("raw_busy", busy_vec, 64'h40);
    wb_pulse(6'd6);
    check("raw_drained", outst, 4'd0);

    // x0 never tracked; float f5 (37) independent of x5.
    drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'd0, 0);
    tick(); idle();
    check("x0_outst", outst, 4'd0);
    check("x0_busy", busy_vec, 64'd0);
    drive(6'd37, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'd37, 0);
    tick();
    check("f5_busy", busy_vec, 64'h20_0000_0000);
    drive(6'd0, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'd0, 0);
    tick(); idle();
    check("f5_outst", outst, 4'd1);
    wb_pulse(6'd37);
    check("f5_drained", outst, 4'd0);

    // Full window: eight writes, ninth stalls, store still issues.
    for (int i = 1; i <= 8; i++) begin
      drive(6'(i), 6'd0, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'(i), 0);
      tick();
    end
    check("full_outst8", outst, 4'd8);
    check("full_busy", busy_vec, 64'h1FE);
    drive(6'd9, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    check("full_stall", issue, 1'b0);
    tick();
    check("full_hold_outst", outst, 4'd8);
    wb_valid = 1'b1; wb_a_rd = 6'd1; expect_issue(6'd9, 1);
    tick();
    wb_valid = 1'b0; wb_a_rd = '0;
    tick(); idle();
    check("full_refill", outst, 4'd8);
    drive(6'd0, 6'd20, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'd0, 0);
    tick(); idle();
    check("full_store_outst", outst, 4'd8);
    for (int i = 2; i <= 9; i++) wb_pulse(6'(i));
    check("full_drained", outst, 4'd0);
    check("full_busy_clear", busy_vec, 64'd0);

    // Branch serialisation.
    drive(6'd0, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0); expect_issue(6'd0, 0);
    tick();
    check("br_waiting", waiting_br, 1'b1);
    drive(6'd10, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'd10, 2);
    tick();
    check("br_stall", issue, 1'b0);
    br_done = 1'b1;
    tick();
    br_done = 1'b0;
    check("br_resolved", waiting_br, 1'b0);
    tick(); idle();
    check("br_outst", outst, 4'd1);
    // Jump with link register.
    drive(6'd11, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0); expect_issue(6'd11, 0);
    tick(); idle();
    check("jal_waiting", waiting_br, 1'b1);
    check("jal_busy", busy_vec, 64'hC00);
    check("jal_outst", outst, 4'd2);
    br_done = 1'b1;
    tick();
    br_done = 1'b0;
    check("jal_resolved", waiting_br, 1'b0);

    // I/O drain: issue only the cycle after the count reaches zero.
    drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1); expect_issue(6'd0, 3);
    tick();
    check("io_stall", issue, 1'b0);
    wb_valid = 1'b1; wb_a_rd = 6'd10;
    tick();
    wb_a_rd = 6'd11;
    check("io_outst1", outst, 4'd1);
    check("io_no_same_cycle", issue, 1'b0);
    tick();
    wb_valid = 1'b0; wb_a_rd = '0;
    check("io_outst0", outst, 4'd0);
    tick(); idle();
    check("io_after", outst, 4'd0);

    // Errors and reset.
    for (int i = 12; i <= 14; i++) begin
      drive(6'(i), 6'd0, 6'd0, 1'b0, 1'b0, 1'b0); expect_issue(6'(i), 0);
      tick();
    end
    idle();
    check("err_outst3", outst, 4'd3);
    wb_pulse(6'd0);
    check("wb_x0_no_err", sb_err, 1'b0);
    check("wb_x0_outst", outst, 4'd3);
    wb_pulse(6'd9);
    check("wb_nonbusy_err", sb_err, 1'b1);
    check("wb_nonbusy_outst", outst, 4'd3);
    check("wb_nonbusy_busy", busy_vec, 64'h7000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outst", outst, 4'd0);
    check("rst_busy", busy_vec, 64'd0);
    check("rst_sb_err", sb_err, 1'b0);
    check("rst_waiting", waiting_br, 1'b0);
    wb_pulse(6'd12);
    check("stale_wb_err", sb_err, 1'b1);
    check("stale_wb_outst", outst, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_sb_err", sb_err, 1'b0);
    br_done = 1'b1;
    tick();
    br_done = 1'b0;
    check("br_in_run_err", sb_err, 1'b1);
    check("br_in_run_state", waiting_br, 1'b0);

    tick(); tick();
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
